// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: ALU op codes, FSM states,
// opcodes and datapath select encodings.
package ctrl_pkg;

  localparam int ALUCTRL_WIDTH = 5;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_LUI  = 5'd5;
  localparam logic [4:0] ALU_ZERO = 5'd31;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2,
    AOP_LUI   = 2'd3
  } alu_op_class_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format is a pure function of the opcode, independent of FSM state.
  function automatic logic [2:0] imm_src_for(input logic [6:0] opcode);
    logic [2:0] imm;
    case (opcode)
      OP_LW, OP_ITYPE: imm = IMM_I;
      OP_SW:           imm = IMM_S;
      OP_BEQ:          imm = IMM_B;
      OP_JAL:          imm = IMM_J;
      OP_LUI:          imm = IMM_U;
      default:         imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus funct fields onto the ALU op code.
// Flags funct3 values the supported instruction set does not implement.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 5
) (
  input  logic [2:0]           iFunct3,
  input  logic                 iFunct7b5,
  input  logic                 iIsRtype,
  input  alu_op_class_e        iAluOpClass,
  output logic [ALUCTRL_W-1:0] oALUControl,
  output logic                 oBadFunct
);

  // Op code selection; funct7b5 only turns add into sub for register-register ops
  always_comb begin
    oALUControl = ALUCTRL_W'(ALU_ADD);
    oBadFunct   = 1'b0;
    case (iAluOpClass)
      AOP_ADD: oALUControl = ALUCTRL_W'(ALU_ADD);
      AOP_SUB: oALUControl = ALUCTRL_W'(ALU_SUB);
      AOP_LUI: oALUControl = ALUCTRL_W'(ALU_LUI);
      AOP_FUNCT: begin
        case (iFunct3)
          3'b000: begin
            if (iIsRtype && iFunct7b5) begin
              oALUControl = ALUCTRL_W'(ALU_SUB);
            end else begin
              oALUControl = ALUCTRL_W'(ALU_ADD);
            end
          end
          3'b010: oALUControl = ALUCTRL_W'(ALU_SLT);
          3'b110: oALUControl = ALUCTRL_W'(ALU_OR);
          3'b111: oALUControl = ALUCTRL_W'(ALU_AND);
          default: begin
            oALUControl = ALUCTRL_W'(ALU_ZERO);
            oBadFunct   = 1'b1;
          end
        endcase
      end
      default: oALUControl = ALUCTRL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch, decode, execute,
// memory and writeback and drives the per-cycle selects, enables and ALU op code.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 5,
  parameter int STATE_W   = 4
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic [6:0]           iOpcode,
  input  logic [2:0]           iFunct3,
  input  logic                 iFunct7b5,
  input  logic                 iZero,
  input  logic                 iMemReady,
  output logic                 oPCWrite,
  output logic                 oAdrSrc,
  output logic                 oMemWrite,
  output logic                 oIRWrite,
  output logic [1:0]           oResultSrc,
  output logic [1:0]           oALUSrcA,
  output logic [1:0]           oALUSrcB,
  output logic [2:0]           oImmSrc,
  output logic                 oRegWrite,
  output logic [ALUCTRL_W-1:0] oALUControl,
  output logic                 oIllegal,
  output logic [STATE_W-1:0]   oState
);

  state_e               state_q;
  state_e               state_d;
  state_e               out_state_s;
  alu_op_class_e        alu_class_s;
  logic                 is_rtype_s;
  logic                 exec_s;
  logic                 bad_funct_s;
  logic                 bad_opcode_s;
  logic                 pc_write_s;
  logic                 ir_write_s;
  logic                 mem_write_s;
  logic                 reg_write_s;
  logic [ALUCTRL_W-1:0] alu_ctrl_s;

  // State register
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // During reset the datapath sees FETCH selects regardless of the registered state.
  assign out_state_s = iRST_n ? state_q : S_FETCH;

  // Next-state logic
  always_comb begin
    state_d      = S_FETCH;
    bad_opcode_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (iMemReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (iOpcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            state_d      = S_FETCH;
            bad_opcode_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (iOpcode == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (iMemReady) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (iMemReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:        state_d = S_FETCH;
      default:                        state_d = S_FETCH;
    endcase
  end

  // Datapath selects and raw enables
  always_comb begin
    oAdrSrc     = 1'b0;
    oResultSrc  = RES_ALUOUT;
    oALUSrcA    = SRCA_PC;
    oALUSrcB    = SRCB_RS2;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    case (out_state_s)
      S_FETCH: begin
        oALUSrcB   = SRCB_FOUR;
        oResultSrc = RES_ALURESULT;
        pc_write_s = iMemReady;
        ir_write_s = iMemReady;
      end
      S_DECODE: begin
        oALUSrcA = SRCA_OLDPC;
        oALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        oALUSrcA = SRCA_RS1;
        oALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: oAdrSrc = 1'b1;
      S_MEMWB: begin
        oResultSrc  = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        oAdrSrc     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR:  oALUSrcA = SRCA_RS1;
      S_ALUWB:  reg_write_s = 1'b1;
      S_BEQ: begin
        oALUSrcA   = SRCA_RS1;
        pc_write_s = iZero;
      end
      S_JAL: begin
        oALUSrcA   = SRCA_OLDPC;
        oALUSrcB   = SRCB_FOUR;
        pc_write_s = 1'b1;
      end
      S_LUI:    oALUSrcB = SRCB_IMM;
      default:  oAdrSrc = 1'b0;
    endcase
  end

  // ALU operation class per state; only the EXEC states consult funct3
  always_comb begin
    alu_class_s = AOP_ADD;
    is_rtype_s  = 1'b0;
    exec_s      = 1'b0;
    case (out_state_s)
      S_EXECR: begin
        alu_class_s = AOP_FUNCT;
        is_rtype_s  = 1'b1;
        exec_s      = 1'b1;
      end
      S_EXECI: begin
        alu_class_s = AOP_FUNCT;
        exec_s      = 1'b1;
      end
      S_BEQ:   alu_class_s = AOP_SUB;
      S_LUI:   alu_class_s = AOP_LUI;
      default: alu_class_s = AOP_ADD;
    endcase
  end

  alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .iFunct3     (iFunct3),
    .iFunct7b5   (iFunct7b5),
    .iIsRtype    (is_rtype_s),
    .iAluOpClass (alu_class_s),
    .oALUControl (alu_ctrl_s),
    .oBadFunct   (bad_funct_s)
  );

  assign oPCWrite    = iRST_n & pc_write_s;
  assign oIRWrite    = iRST_n & ir_write_s;
  assign oMemWrite   = iRST_n & mem_write_s;
  assign oRegWrite   = iRST_n & reg_write_s;
  assign oIllegal    = iRST_n & (bad_opcode_s | (exec_s & bad_funct_s));
  assign oImmSrc     = imm_src_for(iOpcode);
  assign oALUControl = alu_ctrl_s;
  assign oState      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: walks each instruction's state path
// from the instruction-level rules and checks every output every cycle.
module tb_multicycle_control;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic       iCLK = 1'b0;
  logic       iRST_n;
  logic [6:0] iOpcode;
  logic [2:0] iFunct3;
  logic       iFunct7b5;
  logic       iZero;
  logic       iMemReady;
  logic       oPCWrite, oAdrSrc, oMemWrite, oIRWrite, oRegWrite, oIllegal;
  logic [1:0] oResultSrc, oALUSrcA, oALUSrcB;
  logic [2:0] oImmSrc;
  logic [4:0] oALUControl;
  logic [3:0] oState;

  int checks   = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  multicycle_control #(.ALUCTRL_W(5), .STATE_W(4)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iOpcode(iOpcode), .iFunct3(iFunct3),
    .iFunct7b5(iFunct7b5), .iZero(iZero), .iMemReady(iMemReady),
    .oPCWrite(oPCWrite), .oAdrSrc(oAdrSrc), .oMemWrite(oMemWrite), .oIRWrite(oIRWrite),
    .oResultSrc(oResultSrc), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB), .oImmSrc(oImmSrc),
    .oRegWrite(oRegWrite), .oALUControl(oALUControl), .oIllegal(oIllegal), .oState(oState)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] opc);
    return (opc == LW) || (opc == SW) || (opc == RTY) || (opc == ITY) ||
           (opc == BEQ) || (opc == JAL) || (opc == LUI);
  endfunction

  function automatic bit funct_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Reference ALU op for an arithmetic instruction.
  function automatic int alu_ref(input logic [2:0] f3, input logic f7b5, input bit rtype);
    case (f3)
      3'b000:  return (rtype && f7b5) ? 3 : 2;
      3'b010:  return 4;
      3'b110:  return 1;
      3'b111:  return 0;
      default: return 31;
    endcase
  endfunction

  function automatic int imm_ref(input logic [6:0] opc);
    if (opc == SW) return 1;
    if (opc == BEQ) return 2;
    if (opc == JAL) return 3;
    if (opc == LUI) return 4;
    return 0;
  endfunction

  // One clock: at negedge drive inputs, check outputs of state st, then advance to the next negedge.
  task automatic do_cycle(input int st, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7b5, input logic rdy, input logic z, input logic rst_n);
    int es, adr, res, sa, sb, alu;
    bit pcw, irw, mw, rw, ill;
    iRST_n = rst_n; iOpcode = opc; iFunct3 = f3; iFunct7b5 = f7b5; iMemReady = rdy; iZero = z;
    #1;
    es = rst_n ? st : 0;
    adr = 0; res = 0; sa = 0; sb = 0; alu = 2;
    pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    case (es)
      0:  begin res = 2; sb = 2; pcw = rdy; irw = rdy; end
      1:  begin sa = 1; sb = 1; ill = !is_legal(opc); end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = alu_ref(f3, f7b5, 1'b1); ill = !funct_ok(f3); end
      7:  begin sa = 2; sb = 1; alu = alu_ref(f3, f7b5, 1'b0); ill = !funct_ok(f3); end
      8:  rw = 1;
      9:  begin sa = 2; alu = 3; pcw = z; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      11: begin sb = 1; alu = 5; end
      default: alu = 2;
    endcase
    if (!rst_n) begin
      pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    end
    check_eq("state",     32'(oState),      32'(st));
    check_eq("pcwrite",   32'(oPCWrite),    32'(pcw));
    check_eq("irwrite",   32'(oIRWrite),    32'(irw));
    check_eq("memwrite",  32'(oMemWrite),   32'(mw));
    check_eq("regwrite",  32'(oRegWrite),   32'(rw));
    check_eq("illegal",   32'(oIllegal),    32'(ill));
    check_eq("aluctl",    32'(oALUControl), 32'(alu));
    check_eq("resultsrc", 32'(oResultSrc),  32'(res));
    check_eq("alusrca",   32'(oALUSrcA),    32'(sa));
    check_eq("alusrcb",   32'(oALUSrcB),    32'(sb));
    check_eq("adrsrc",    32'(oAdrSrc),     32'(adr));
    check_eq("immsrc",    32'(oImmSrc),     32'(imm_ref(opc)));
    @(negedge iCLK);
  endtask

  // mem_stalls < 0: random handshake stalls; otherwise exactly that many in MEMREAD/MEMWRITE.
  // zero_mode < 0: random iZero; otherwise constant.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5,
                           input int mem_stalls, input int zero_mode);
    int   path[$];
    int   st;
    int   stalls;
    bit   waits;
    logic rdy, z;
    path = '{0, 1};
    if (opc == LW)  begin path.push_back(2); path.push_back(3); path.push_back(4); end
    if (opc == SW)  begin path.push_back(2); path.push_back(5); end
    if (opc == RTY) begin path.push_back(6); path.push_back(8); end
    if (opc == ITY) begin path.push_back(7); path.push_back(8); end
    if (opc == BEQ) path.push_back(9);
    if (opc == JAL) begin path.push_back(10); path.push_back(8); end
    if (opc == LUI) begin path.push_back(11); path.push_back(8); end
    foreach (path[k]) begin
      st     = path[k];
      waits  = (st == 0) || (st == 3) || (st == 5);
      stalls = 0;
      forever begin
        if (!waits)               rdy = 1'($urandom_range(0, 1));
        else if (mem_stalls >= 0) rdy = (st == 0) ? 1'b1 : (stalls >= mem_stalls);
        else                      rdy = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
        z = (zero_mode >= 0) ? zero_mode[0] : 1'($urandom_range(0, 1));
        do_cycle(st, opc, f3, f7b5, rdy, z, 1'b1);
        if (!waits || rdy) break;
        stalls++;
      end
    end
  endtask

  initial begin
    logic [6:0] opc;
    iRST_n = 1'b0; iOpcode = 7'd0; iFunct3 = 3'd0; iFunct7b5 = 1'b0; iZero = 1'b0; iMemReady = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    // Reset state with ready high: fetch enables must stay low.
    do_cycle(0, SW, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset asserted for two edges while stalled in MEMWRITE.
    do_cycle(0, SW, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    do_cycle(1, SW, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    do_cycle(2, SW, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    do_cycle(5, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    do_cycle(5, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(0, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(0, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);

    // Directed instructions.
    run_instr(RTY, 3'b000, 1'b0, 0, 0);
    run_instr(RTY, 3'b000, 1'b1, 0, 0);
    run_instr(LW,  3'b010, 1'b0, 3, 0);
    run_instr(SW,  3'b010, 1'b0, 2, 0);
    run_instr(BEQ, 3'b000, 1'b0, 0, 1);
    run_instr(BEQ, 3'b000, 1'b0, 0, 0);
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0);
    run_instr(RTY, 3'b001, 1'b0, 0, 0);
    run_instr(ITY, 3'b000, 1'b1, 0, 0);
    run_instr(ITY, 3'b101, 1'b0, 0, 0);
    run_instr(LUI, 3'b011, 1'b1, 0, 0);
    run_instr(JAL, 3'b100, 1'b0, 0, 0);

    // Randomized instruction stream with random handshake stalls.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 8))
        0: opc = LW;
        1: opc = SW;
        2: opc = RTY;
        3: opc = ITY;
        4: opc = BEQ;
        5: opc = JAL;
        6: opc = LUI;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      run_instr(opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
